// File: rtl/iccm_arbiter.sv
// rtl/iccm_arbiter.sv - ICCM SRAM sharing between boot programmer writes and fetch reads.
// Optional performance counters are built when ICCM_ARB_PERF_EN is defined.
module iccm_arbiter #(
   parameter int unsigned AddrWidth = 12,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned FifoDepth = 4,
   parameter int unsigned StarveMax = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 prog_we_i,
   input  logic [AddrWidth-1:0] prog_addr_i,
   input  logic [DataWidth-1:0] prog_wdata_i,
   input  logic                 prog_done_i,
   input  logic                 fetch_req_i,
   input  logic [AddrWidth-1:0] fetch_addr_i,
   output logic                 fetch_gnt_o,
   output logic                 fetch_rvalid_o,
   output logic [DataWidth-1:0] fetch_rdata_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [DataWidth-1:0] mem_wdata_o,
   input  logic [DataWidth-1:0] mem_rdata_i,
   output logic                 core_hold_o,
   output logic                 prog_overflow_o
`ifdef ICCM_ARB_PERF_EN
   ,
   output logic [31:0]          perf_reads_o,
   output logic [31:0]          perf_writes_o,
   output logic [31:0]          perf_stalls_o
`endif
);

   localparam int unsigned PtrW = $clog2(FifoDepth);
   localparam int unsigned CntW = $clog2(FifoDepth + 1);
   localparam int unsigned StW  = $clog2(StarveMax + 1);

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]     count_q, count_d;
   logic [StW-1:0]      starve_q, starve_d;
   logic                rvalid_q;
   logic                overflow_q, overflow_d;
   logic [AddrWidth-1:0] fifo_addr_q [FifoDepth];
   logic [DataWidth-1:0] fifo_data_q [FifoDepth];

   logic fifo_empty, fifo_full, pop, push, gnt, hold;

   always_comb begin
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == CntW'(FifoDepth));
      pop        = 1'b0;
      gnt        = 1'b0;
      hold       = 1'b1;
      state_d    = state_q;

      unique case (state_q)
         ST_HOLD, ST_DRAIN: pop = !fifo_empty;
         ST_RUN: begin
            hold = 1'b0;
            if (!fifo_empty && (starve_q == StW'(StarveMax))) begin
               pop = 1'b1;
            end else if (fetch_req_i) begin
               gnt = 1'b1;
            end else if (!fifo_empty) begin
               pop = 1'b1;
            end
         end
         default: ;
      endcase

      // A pop frees a slot in the same cycle, so a push at full is legal then.
      push       = prog_we_i && (!fifo_full || pop);
      overflow_d = overflow_q | (prog_we_i && fifo_full && !pop);

      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end

      starve_d = starve_q;
      if (fifo_empty || pop) begin
         starve_d = '0;
      end else if (gnt && (starve_q != StW'(StarveMax))) begin
         starve_d = starve_q + 1'b1;
      end

      unique case (state_q)
         ST_HOLD: begin
            if (prog_done_i) begin
               state_d = (count_d == '0) ? ST_RUN : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (count_d == '0) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_HOLD;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_HOLD;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         starve_q   <= '0;
         rvalid_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         starve_q   <= starve_d;
         rvalid_q   <= gnt;
         overflow_q <= overflow_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= prog_addr_i;
         fifo_data_q[wr_ptr_q] <= prog_wdata_i;
      end
   end

   assign fetch_gnt_o     = gnt;
   assign fetch_rvalid_o  = rvalid_q;
   assign fetch_rdata_o   = rvalid_q ? mem_rdata_i : '0;
   assign mem_req_o       = pop | gnt;
   assign mem_we_o        = pop;
   assign mem_addr_o      = pop ? fifo_addr_q[rd_ptr_q] : (gnt ? fetch_addr_i : '0);
   assign mem_wdata_o     = pop ? fifo_data_q[rd_ptr_q] : '0;
   assign core_hold_o     = hold;
   assign prog_overflow_o = overflow_q;

`ifdef ICCM_ARB_PERF_EN
   logic [31:0] perf_reads_q, perf_writes_q, perf_stalls_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         perf_reads_q  <= '0;
         perf_writes_q <= '0;
         perf_stalls_q <= '0;
      end else begin
         if (gnt && (perf_reads_q != '1)) begin
            perf_reads_q <= perf_reads_q + 1'b1;
         end
         if (pop && (perf_writes_q != '1)) begin
            perf_writes_q <= perf_writes_q + 1'b1;
         end
         if (fetch_req_i && !gnt && (perf_stalls_q != '1)) begin
            perf_stalls_q <= perf_stalls_q + 1'b1;
         end
      end
   end

   assign perf_reads_o  = perf_reads_q;
   assign perf_writes_o = perf_writes_q;
   assign perf_stalls_o = perf_stalls_q;
`endif

endmodule

// File: tb/tb_iccm_arbiter.sv
// tb/tb_iccm_arbiter.sv - directed and random checks of iccm_arbiter against a queue-based model.
module tb_iccm_arbiter;
   localparam int AW    = 12;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int SMAX  = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          prog_we_i = 1'b0;
   logic [AW-1:0] prog_addr_i = '0;
   logic [DW-1:0] prog_wdata_i = '0;
   logic          prog_done_i = 1'b0;
   logic          fetch_req_i = 1'b0;
   logic [AW-1:0] fetch_addr_i = '0;
   logic          fetch_gnt_o, fetch_rvalid_o;
   logic [DW-1:0] fetch_rdata_o;
   logic          mem_req_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i = '0;
   logic          core_hold_o, prog_overflow_o;
`ifdef ICCM_ARB_PERF_EN
   logic [31:0]   perf_reads_o, perf_writes_o, perf_stalls_o;
`endif

   always #5 clock = ~clock;

   iccm_arbiter #(.AddrWidth(AW), .DataWidth(DW), .FifoDepth(DEPTH), .StarveMax(SMAX)) dut (
      .clock(clock), .reset(reset),
      .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i), .prog_wdata_i(prog_wdata_i),
      .prog_done_i(prog_done_i),
      .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
      .fetch_gnt_o(fetch_gnt_o), .fetch_rvalid_o(fetch_rvalid_o), .fetch_rdata_o(fetch_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .core_hold_o(core_hold_o), .prog_overflow_o(prog_overflow_o)
`ifdef ICCM_ARB_PERF_EN
      , .perf_reads_o(perf_reads_o), .perf_writes_o(perf_writes_o), .perf_stalls_o(perf_stalls_o)
`endif
   );

   int nchecks = 0;
   int nerr    = 0;

   // Reference model: a queue for the FIFO, a phase number and a starvation tally.
   logic [AW-1:0] mq_a [$];
   logic [DW-1:0] mq_d [$];
   int  mphase;   // 0 programming, 1 draining, 2 running
   int  mstarve;
   bit  movf;
   bit  mprev_gnt;

   bit            obs_gnt, obs_we, obs_hold, obs_rvalid, obs_ovf;
   logic [AW-1:0] obs_addr;
   logic [DW-1:0] obs_rdata;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq_a.delete();
      mq_d.delete();
      mphase    = 0;
      mstarve   = 0;
      movf      = 1'b0;
      mprev_gnt = 1'b0;
   endtask

   task automatic cycle(input bit rst, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit done, input bit freq, input logic [AW-1:0] fa, input logic [DW-1:0] rd);
      int  sz;
      bit  e_pop, e_gnt, e_hold;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      @(negedge clock);
      reset = rst; prog_we_i = we; prog_addr_i = a; prog_wdata_i = d;
      prog_done_i = done; fetch_req_i = freq; fetch_addr_i = fa; mem_rdata_i = rd;
      #1;
      if (rst) begin
         @(posedge clock);
         model_reset();
         return;
      end
      sz = mq_a.size();
      e_pop = 1'b0; e_gnt = 1'b0; e_hold = (mphase != 2);
      if (mphase != 2) begin
         e_pop = (sz > 0);
      end else if (sz > 0 && mstarve == SMAX) begin
         e_pop = 1'b1;
      end else if (freq) begin
         e_gnt = 1'b1;
      end else begin
         e_pop = (sz > 0);
      end
      e_addr  = e_pop ? mq_a[0] : (e_gnt ? fa : '0);
      e_wdata = e_pop ? mq_d[0] : '0;

      chk("mem_req",   64'(mem_req_o),      64'(e_pop | e_gnt));
      chk("mem_we",    64'(mem_we_o),       64'(e_pop));
      chk("mem_addr",  64'(mem_addr_o),     64'(e_addr));
      chk("mem_wdata", 64'(mem_wdata_o),    64'(e_wdata));
      chk("fetch_gnt", 64'(fetch_gnt_o),    64'(e_gnt));
      chk("rvalid",    64'(fetch_rvalid_o), 64'(mprev_gnt));
      chk("rdata",     64'(fetch_rdata_o),  64'(mprev_gnt ? rd : '0));
      chk("core_hold", 64'(core_hold_o),    64'(e_hold));
      chk("overflow",  64'(prog_overflow_o), 64'(movf));

      obs_gnt = fetch_gnt_o; obs_we = mem_we_o; obs_hold = core_hold_o;
      obs_rvalid = fetch_rvalid_o; obs_ovf = prog_overflow_o;
      obs_addr = mem_addr_o; obs_rdata = fetch_rdata_o;

      @(posedge clock);
      if (e_pop) begin
         void'(mq_a.pop_front());
         void'(mq_d.pop_front());
      end
      if (we) begin
         if (sz < DEPTH || e_pop) begin
            mq_a.push_back(a);
            mq_d.push_back(d);
         end else begin
            movf = 1'b1;
         end
      end
      if (e_pop || sz == 0) mstarve = 0;
      else if (e_gnt && mstarve < SMAX) mstarve++;
      if (mphase == 0 && done) mphase = (mq_a.size() == 0) ? 2 : 1;
      else if (mphase == 1 && mq_a.size() == 0) mphase = 2;
      mprev_gnt = e_gnt;
   endtask

   task automatic step(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit done, input bit freq, input logic [AW-1:0] fa);
      cycle(1'b0, we, a, d, done, freq, fa, DW'($urandom));
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      int grants;
      bit forced;
      model_reset();
      do_reset();

      // Reset state and programming of three words.
      step(1'b0, '0, '0, 1'b0, 1'b0, '0);
      chk("rst_hold", 64'(obs_hold), 64'd1);
      step(1'b1, 12'd0, 32'hA0, 1'b0, 1'b0, '0);
      step(1'b1, 12'd1, 32'hA1, 1'b0, 1'b0, '0);
      step(1'b1, 12'd2, 32'hA2, 1'b0, 1'b0, '0);
      step(1'b0, '0, '0, 1'b1, 1'b0, '0);
      chk("t1_last_hold", 64'(obs_hold), 64'd1);
      chk("t1_last_addr", 64'(obs_addr), 64'd2);
      step(1'b0, '0, '0, 1'b0, 1'b0, '0);
      chk("t1_run_hold", 64'(obs_hold), 64'd0);

      // Six back-to-back writes while programming: the per-cycle pop keeps up.
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b1, AW'(i + 16), DW'($urandom), 1'b0, 1'b0, '0);
      step(1'b0, '0, '0, 1'b0, 1'b0, '0);
      chk("t2_no_ovf", 64'(obs_ovf), 64'd0);

      // Done together with the fourth write drains before running.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, AW'(i), DW'($urandom), 1'b0, 1'b1, 12'h100);
      step(1'b1, 12'd3, 32'hC3, 1'b1, 1'b1, 12'h100);
      chk("t3_drain_gnt", 64'(obs_gnt), 64'd0);
      step(1'b0, '0, '0, 1'b0, 1'b1, 12'h100);
      chk("t3_drain_hold", 64'(obs_hold), 64'd1);
      chk("t3_drain_addr", 64'(obs_addr), 64'd3);
      step(1'b0, '0, '0, 1'b0, 1'b1, 12'h100);
      chk("t3_run_hold", 64'(obs_hold), 64'd0);
      chk("t3_run_gnt", 64'(obs_gnt), 64'd1);

      // Starvation bound: one pending write under continuous fetch.
      step(1'b1, 12'h222, 32'h5555_AAAA, 1'b0, 1'b1, 12'h040);
      grants = 0; forced = 1'b0;
      for (int i = 0; i < 20 && !forced; i++) begin
         step(1'b0, '0, '0, 1'b0, 1'b1, AW'(12'h041 + i));
         if (obs_we) forced = 1'b1;
         else if (obs_gnt) grants++;
      end
      chk("t4_forced", 64'(forced), 64'd1);
      chk("t4_grants", 64'(grants), 64'(SMAX));
      step(1'b0, '0, '0, 1'b0, 1'b1, 12'h060);
      chk("t4_resume", 64'(obs_gnt), 64'd1);

      // Read data returns one cycle after the grant.
      step(1'b0, '0, '0, 1'b0, 1'b1, 12'h010);
      chk("t5_gnt", 64'(obs_gnt), 64'd1);
      chk("t5_addr", 64'(obs_addr), 64'h010);
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 32'hDEADBEEF);
      chk("t5_rvalid", 64'(obs_rvalid), 64'd1);
      chk("t5_rdata", 64'(obs_rdata), 64'hDEADBEEF);

      // Five writes under continuous fetch overflow a four-entry FIFO.
      for (int i = 0; i < 5; i++) step(1'b1, AW'(12'h300 + i), DW'($urandom), 1'b0, 1'b1, 12'h070);
      step(1'b0, '0, '0, 1'b0, 1'b1, 12'h071);
      chk("t6_ovf", 64'(obs_ovf), 64'd1);
      for (int i = 0; i < 40; i++) step(1'b0, '0, '0, 1'b0, 1'b1, AW'(i));
      chk("t6_ovf_sticky", 64'(obs_ovf), 64'd1);
      do_reset();
      step(1'b0, '0, '0, 1'b0, 1'b0, '0);
      chk("t6_ovf_clear", 64'(obs_ovf), 64'd0);

      // Random traffic, including occasional mid-operation resets.
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom),
               $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, AW'($urandom), DW'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end
endmodule

// File: doc/iccm_arbiter.md
Name: iccm_arbiter

Overview:
- Sequences and shares the single-port ICCM SRAM between two requesters:
  - the UART boot programmer (write stream from iccm_controller);
  - the instruction-fetch path (read requests from the ICCM tlul_sram_adapter).
- Buffers programmer writes in a small FIFO and holds the core in reset until programming completes.
- After programming, interleaves fetch reads with late programmer writes under starvation-bounded priority.

Parameters:
- AddrWidth, 12, ICCM word-address width.
- DataWidth, 32, ICCM data width.
- FifoDepth, 4, programmer write FIFO entries; power of 2, minimum 2.
- StarveMax, 8, consecutive cycles a pending write may lose to fetch before it is forced; minimum 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- prog_we_i  in  1  programmer write strobe, one word per pulse.
- prog_addr_i  in  AddrWidth  programmer write address.
- prog_wdata_i  in  DataWidth  programmer write data.
- prog_done_i  in  1  programming-complete pulse (iccm_controller reset_o).
- fetch_req_i  in  1  fetch read request.
- fetch_addr_i  in  AddrWidth  fetch read address.
- fetch_gnt_o  out  1  fetch request accepted this cycle.
- fetch_rvalid_o  out  1  fetch read data valid.
- fetch_rdata_o  out  DataWidth  fetch read data.
- mem_req_o  out  1  SRAM access strobe.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  AddrWidth  SRAM address.
- mem_wdata_o  out  DataWidth  SRAM write data.
- mem_rdata_i  in  DataWidth  SRAM read data, valid the cycle after a read strobe.
- core_hold_o  out  1  1 = keep the core/system in reset.
- prog_overflow_o  out  1  sticky: a programmer write was dropped.

Behaviour:
- Reset values: core_hold_o=1; every other output 0; FIFO empty; starve counter 0; state HOLD.
- A reset asserted mid-operation flushes the FIFO, clears any in-flight rvalid on the next cycle, and clears prog_overflow_o.
- FIFO push: prog_we_i=1 and FIFO not full.
- FIFO push when full:
  - push occurs only if a pop happens the same cycle (simultaneous push/pop at full is legal, no drop);
  - otherwise the word is dropped and prog_overflow_o is set; it stays set until reset.
- FIFO order is strict FIFO. Empty and full are exact at 0 and FifoDepth entries; pointers wrap modulo FifoDepth.
- Only one SRAM access per cycle: mem_req_o = pop | fetch_gnt_o.
  - On pop: mem_we_o=1, mem_addr_o/mem_wdata_o = FIFO head.
  - On fetch grant: mem_we_o=0, mem_addr_o=fetch_addr_i.
- Read timing:
  - fetch_gnt_o is combinational in the request cycle;
  - fetch_rvalid_o=1 exactly one cycle after a grant, with fetch_rdata_o=mem_rdata_i that cycle;
  - fetch_rdata_o=0 when rvalid=0.
- State HOLD:
  - core_hold_o=1; fetch_gnt_o=0;
  - FIFO pops every cycle it is non-empty;
  - prog_done_i=1 with FIFO empty (after any same-cycle pop) -> RUN; with FIFO non-empty -> DRAIN.
- State DRAIN:
  - core_hold_o=1; fetch_gnt_o=0; pops every cycle;
  - -> RUN in the cycle after the last entry pops (FIFO empty).
- State RUN:
  - core_hold_o=0;
  - fetch has priority: fetch_req_i=1 -> grant fetch, no pop;
  - pending write with no fetch request -> pop;
  - starve counter increments each cycle the FIFO is non-empty and fetch wins;
  - when the counter equals StarveMax, the write is forced: pop, fetch_gnt_o=0 that cycle, counter cleared;
  - counter also clears on any pop and whenever the FIFO is empty;
  - prog_done_i is ignored in RUN.
- Counter width: clog2(StarveMax+1); it saturates at StarveMax and never wraps.
- prog_done_i in the same cycle as prog_we_i: the write is pushed first, so the HOLD transition sees a non-empty FIFO and goes to DRAIN.

Optional Feature:
- Macro: ICCM_ARB_PERF_EN.
- Defined: adds outputs perf_reads_o[31:0], perf_writes_o[31:0] and perf_stalls_o[31:0].
  - perf_reads_o counts fetch grants; perf_writes_o counts pops; perf_stalls_o counts cycles where fetch_req_i=1 and fetch_gnt_o=0.
  - All three saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, 3 programmer writes (addr 0,1,2 / data A0,A1,A2) one per cycle, then prog_done_i -> 3 SRAM writes in order; core_hold_o=1 until the cycle after the last pop, then 0; FIFO returns to empty.
- 6 back-to-back programmer writes in HOLD, FifoDepth=4 -> no drops, since a pop occurs every cycle; prog_overflow_o stays 0.
- prog_done_i in the same cycle as the 4th write -> DRAIN; RUN is entered only after word 4 is written; no fetch grant before RUN.
- RUN, fetch_req_i held high continuously, one pending write, StarveMax=8 -> 8 fetch grants, then one forced write with fetch_gnt_o=0 that cycle, then grants resume.
- RUN, fetch read addr 0x010 with mem_rdata_i=DEADBEEF -> fetch_rvalid_o=1 and fetch_rdata_o=DEADBEEF exactly one cycle after the grant.
- RUN, fetch_req_i high while 5 writes arrive with FifoDepth=4 and no forced pop before the 5th -> the 5th write is dropped and prog_overflow_o=1 until reset.
